alu_result_writeback: RTL and testbench
=======================================

# alu_result_writeback

Sequential consumer for the bitwise ALU unit's 65-bit `bquad_t` result.
- Buffers results and their destination register in a small FIFO.
- Drains them to the register-file write port as one-cycle write pulses.
- Maintains the architectural carry flag, plus the optional zero flag.
- Sits between the bitwise unit's output and the register file, decoupling ALU issue from register-file port availability.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `REG_ADDR_W`, 5: destination register address width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  result offered.
- `in_ready`  out  1  FIFO can accept.
- `in_op`  in  `opcode_t`  opcode that produced the result.
- `in_dest`  in  `REG_ADDR_W`  destination register.
- `in_result`  in  `bquad_t` (65)  bit 64 = carry-out, [63:0] = value.
- `flush`  in  1  discard all buffered entries.
- `rf_stall`  in  1  register-file port unavailable this cycle.
- `rf_we`  out  1  write pulse.
- `rf_waddr`  out  `REG_ADDR_W`  write address.
- `rf_wdata`  out  64  write data.
- `carry_flag`  out  1  architectural carry.
- `zero_flag`  out  1  architectural zero (see Configuration).
- `pending`  out  `$clog2(DEPTH+1)`  entries currently buffered.

## Operation
- Push occurs when `in_valid && in_ready`. Each entry holds {op, dest, result}.
- `in_ready` = !full && !flush && `rst_n`. It has no combinational path from `rf_stall`.
- Pop occurs when !empty && !`rf_stall` && !`flush`.
  - On the next edge: `rf_we`=1, `rf_waddr`=dest, `rf_wdata`=result[63:0].
  - Otherwise `rf_we`=0 on the next edge.
- If dest==0, `rf_we` stays 0 for that entry; flags still update.
- Carry update on pop:
  - Shift-class ops (SHIFTR, SHIFTL, SHIFTRC, SHIFTLC and the ASHIFT* forms): `carry_flag` <= result[64].
  - AND/OR/XOR/NOT and their A-forms: carry unchanged.
  - Any other opcode: carry unchanged; the value is still written.
- Push and pop may occur in the same cycle. `pending` is unchanged in that case and the pointers advance independently, wrapping modulo DEPTH.
- Flush:
  - Zeroes both pointers and `pending` on the next edge.
  - The push in the flush cycle is refused.
  - No pop occurs in the flush cycle, so `rf_we`=0 next cycle.
  - Flags are untouched.
- Reset (asynchronous): pointers, `pending`, `rf_we`, `rf_waddr`, `rf_wdata`, `carry_flag` and `zero_flag` all go to 0. `in_ready`=0 while `rst_n` is low.

## Timing
- Latency from accept to `rf_we` is 1 cycle when the FIFO is empty and `rf_stall` is low (accepted at edge N, `rf_we` high after edge N+1).
- Flags change on the same edge that raises `rf_we` for the entry.
- Throughput is one entry per cycle in and one out.
- Full (`pending`==DEPTH): `in_ready` is low even if a pop occurs that cycle; it rises the cycle after.
- With `rf_stall` held high, entries remain queued indefinitely and `rf_we` stays low.
- All outputs except `in_ready` are registered.

## Configuration
- Macro: `ALU_WB_ZERO_FLAG_EN`.
- Defined: `zero_flag` <= (result[63:0]==0) on every pop, regardless of op or dest.
- Undefined: the zero-detect logic is absent and `zero_flag` is tied to 0. The port remains present.

## Structure
- Add to the shared `defines` package:
  - constant `CARRY_BIT` = 64;
  - function `is_shift_op(opcode_t)` returning 1 for the eight shift-class opcodes.
- One sub-module, `result_fifo`: parameterised DEPTH/WIDTH circular buffer with push, pop, flush, full, empty and count. `alu_result_writeback` wraps it with flag and write-port logic.

## Test plan
- Reset then single push (SHIFTL, dest=3, result=65'h1_0000_0000_0000_0002) → one cycle later `rf_we`=1, `rf_waddr`=3, `rf_wdata`=64'h2, `carry_flag`=1.
- AND with result bit 64 set, following the above → value written, `carry_flag` stays 1. A subsequent SHIFTR with bit 64=0 → `carry_flag`=0.
- `rf_stall` high; push 4 entries (DEPTH=4) → `pending`=4, `in_ready`=0, no `rf_we`. Release the stall → four consecutive `rf_we` pulses in FIFO order, then `pending`=0.
- dest=0 with value 64'hFFFF → `rf_we` never asserted; `carry_flag` still updates for a shift op.
- Three entries queued, assert `flush` together with `in_valid` → input refused, `pending`=0 next cycle, no further `rf_we`, flags unchanged.
- With `ALU_WB_ZERO_FLAG_EN`: XOR result 0 → `zero_flag`=1; next result 5 → `zero_flag`=0. Without the macro, `zero_flag` stays 0. Reset asserted mid-drain → all outputs 0 asynchronously.

Source files
------------

// File: rtl/alu_result_writeback_pkg.sv
// alu_result_writeback_pkg
//   Types and helpers shared between the bitwise ALU unit and its writeback
//   stage: the opcode encoding, the 65-bit bquad_t result (carry-out in bit
//   64, value in [63:0]), the carry bit position and the shift-class test.
package alu_result_writeback_pkg;

  typedef enum logic [4:0] {
    AND      = 5'd0,
    OR       = 5'd1,
    XOR      = 5'd2,
    NOT      = 5'd3,
    AAND     = 5'd4,
    AOR      = 5'd5,
    AXOR     = 5'd6,
    ANOT     = 5'd7,
    SHIFTR   = 5'd8,
    SHIFTL   = 5'd9,
    SHIFTRC  = 5'd10,
    SHIFTLC  = 5'd11,
    ASHIFTR  = 5'd12,
    ASHIFTL  = 5'd13,
    ASHIFTRC = 5'd14,
    ASHIFTLC = 5'd15,
    PASS     = 5'd16,
    NOP      = 5'd17
  } opcode_t;

  typedef logic [64:0] bquad_t;

  localparam int CARRY_BIT = 64;

  // Only the shift family produces a meaningful carry-out; every other
  // opcode leaves the architectural carry alone.
  function automatic logic is_shift_op(input opcode_t op);
    case (op)
      SHIFTR, SHIFTL, SHIFTRC, SHIFTLC,
      ASHIFTR, ASHIFTL, ASHIFTRC, ASHIFTLC: return 1'b1;
      default:                              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_result_writeback_fifo.sv
// result_fifo
//   Circular buffer of DEPTH entries (DEPTH a power of two, so the pointers
//   wrap naturally), WIDTH bits each. The head entry is visible on rdata
//   without a read cycle.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, wdata         write wdata at the tail (ignored when full or flushing)
//   pop                 drop the head entry (ignored when empty or flushing)
//   flush               empty the buffer on the next edge
//   rdata               current head entry
//   full, empty, count  occupancy status
module result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rdata   = mem[rd_ptr];

  // Storage carries no reset; validity is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_writeback.sv
// alu_result_writeback
//   Buffers bitwise-ALU results with their destination register and drains
//   them to the register-file write port as single-cycle write pulses, while
//   maintaining the architectural carry (and optionally zero) flag.
//   Optional feature macro: ALU_WB_ZERO_FLAG_EN (zero flag tracking; when
//   undefined zero_flag is tied low).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     result handshake; in_op, in_dest, in_result payload
//   flush                 discard everything buffered
//   rf_stall              register-file port busy this cycle
//   rf_we/rf_waddr/rf_wdata  registered write port
//   carry_flag, zero_flag architectural flags
//   pending               number of buffered entries
module alu_result_writeback
  import alu_result_writeback_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int REG_ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  opcode_t                      in_op,
  input  logic [REG_ADDR_W-1:0]        in_dest,
  input  bquad_t                       in_result,
  input  logic                         flush,
  input  logic                         rf_stall,
  output logic                         rf_we,
  output logic [REG_ADDR_W-1:0]        rf_waddr,
  output logic [63:0]                  rf_wdata,
  output logic                         carry_flag,
  output logic                         zero_flag,
  output logic [$clog2(DEPTH+1)-1:0]   pending
);

  localparam int RES_W   = $bits(bquad_t);
  localparam int OP_W    = $bits(opcode_t);
  localparam int ENTRY_W = OP_W + REG_ADDR_W + RES_W;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [ENTRY_W-1:0]    head;
  opcode_t               head_op;
  logic [REG_ADDR_W-1:0] head_dest;
  bquad_t                head_result;

  // in_ready depends only on occupancy, flush and reset so that rf_stall
  // never reaches the upstream handshake combinationally.
  assign in_ready = !full && !flush && rst_n;
  assign push     = in_valid && in_ready;
  assign pop      = !empty && !rf_stall && !flush;

  result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ({in_op, in_dest, in_result}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (pending)
  );

  assign head_op     = opcode_t'(head[ENTRY_W-1 -: OP_W]);
  assign head_dest   = head[RES_W +: REG_ADDR_W];
  assign head_result = head[RES_W-1:0];

  // Write port and carry. Register 0 is never written, but the entry still
  // retires and still updates the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      carry_flag <= 1'b0;
    end else begin
      rf_we <= pop && (head_dest != '0);
      if (pop) begin
        rf_waddr <= head_dest;
        rf_wdata <= head_result[63:0];
        if (is_shift_op(head_op)) carry_flag <= head_result[CARRY_BIT];
      end
    end
  end

`ifdef ALU_WB_ZERO_FLAG_EN
  // Zero flag follows every retired value regardless of opcode or dest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_flag <= 1'b0;
    end else if (pop) begin
      zero_flag <= (head_result[63:0] == 64'd0);
    end
  end
`else
  assign zero_flag = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_writeback.sv
// tb_alu_result_writeback
//   Directed stimulus for alu_result_writeback. Expected register-file
//   writes (address, data, carry after the write) are queued when each
//   result is offered; a monitor on the falling edge retires them whenever
//   rf_we is seen. Occupancy, handshake and flag values are checked inline.
//   Honours ALU_WB_ZERO_FLAG_EN for the zero-flag expectations.
module tb_alu_result_writeback;
  import alu_result_writeback_pkg::*;

  typedef struct {
    logic [4:0]  addr;
    logic [63:0] data;
    logic        carry;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  opcode_t     in_op;
  logic [4:0]  in_dest;
  bquad_t      in_result;
  logic        flush;
  logic        rf_stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        carry_flag;
  logic        zero_flag;
  logic [2:0]  pending;

  exp_t exp_q[$];
  int   assert_count = 0;
  int   fail_count   = 0;
  int   write_count  = 0;
  int   writes_before;

  alu_result_writeback #(
    .DEPTH      (4),
    .REG_ADDR_W (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_dest    (in_dest),
    .in_result  (in_result),
    .flush      (flush),
    .rf_stall   (rf_stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .pending    (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Offer one result for exactly one rising edge; queue the write it should
  // produce when one is expected.
  task automatic applyStimulus(input opcode_t op, input logic [4:0] dest,
                               input bquad_t res, input logic exp_write,
                               input logic exp_carry);
    exp_t e;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = op;
    in_dest   = dest;
    in_result = res;
    if (exp_write) begin
      e.addr  = dest;
      e.data  = res[63:0];
      e.carry = exp_carry;
      exp_q.push_back(e);
    end
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  // Scoreboard monitor: every write pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rf_we === 1'b1) begin
      write_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", {59'd0, rf_waddr}, 64'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("write_addr",  {59'd0, rf_waddr}, {59'd0, e.addr});
        checkOutput("write_data",  rf_wdata,          e.data);
        checkOutput("write_carry", {63'd0, carry_flag}, {63'd0, e.carry});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    in_valid  = 1'b0;
    in_op     = NOP;
    in_dest   = '0;
    in_result = '0;
    flush     = 1'b0;
    rf_stall  = 1'b0;
    rst_n     = 1'b0;

    #3;
    checkOutput("reset_in_ready", {63'd0, in_ready},   64'd0);
    checkOutput("reset_rf_we",    {63'd0, rf_we},      64'd0);
    checkOutput("reset_pending",  {61'd0, pending},    64'd0);
    checkOutput("reset_carry",    {63'd0, carry_flag}, 64'd0);
    checkOutput("reset_zero",     {63'd0, zero_flag},  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("ready_after_reset", {63'd0, in_ready}, 64'd1);

    // Single shift result: carry-out set, written one cycle after accept.
    applyStimulus(SHIFTL, 5'd3, 65'h1_0000_0000_0000_0002, 1'b1, 1'b1);
    idleCycles(3);

    // AND leaves carry at 1; SHIFTR with carry-out 0 clears it.
    applyStimulus(AND,    5'd4, 65'h1_0000_0000_0000_00AA, 1'b1, 1'b1);
    applyStimulus(SHIFTR, 5'd5, 65'h0_0000_0000_0000_0010, 1'b1, 1'b0);
    idleCycles(3);

    // Fill the FIFO under stall, then drain in order.
    rf_stall = 1'b1;
    writes_before = write_count;
    applyStimulus(OR,      5'd6, 65'h1_0000_0000_0000_1111, 1'b1, 1'b0);
    applyStimulus(SHIFTLC, 5'd7, 65'h1_2222_0000_0000_2222, 1'b1, 1'b1);
    applyStimulus(XOR,     5'd8, 65'h1_0000_0000_3333_0000, 1'b1, 1'b1);
    applyStimulus(ASHIFTR, 5'd9, 65'h0_4444_4444_4444_4444, 1'b1, 1'b0);
    idleCycles(1);
    checkOutput("full_pending",  {61'd0, pending},  64'd4);
    checkOutput("full_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("stall_no_write", write_count, writes_before);
    rf_stall = 1'b0;
    idleCycles(6);
    checkOutput("drained_pending", {61'd0, pending}, 64'd0);
    checkOutput("drained_writes",  write_count, writes_before + 4);

    // Destination 0: no write, but the shift still updates carry.
    writes_before = write_count;
    applyStimulus(SHIFTRC, 5'd0, 65'h1_0000_0000_0000_FFFF, 1'b0, 1'b0);
    idleCycles(3);
    checkOutput("dest0_no_write", write_count, writes_before);
    checkOutput("dest0_carry", {63'd0, carry_flag}, 64'd1);
    checkOutput("dest0_zero",  {63'd0, zero_flag},  64'd0);

    // Flush with three entries queued and a concurrent offer.
    rf_stall = 1'b1;
    writes_before = write_count;
    applyStimulus(AND, 5'd10, 65'h0_0000_0000_0000_000A, 1'b0, 1'b0);
    applyStimulus(AND, 5'd11, 65'h0_0000_0000_0000_000B, 1'b0, 1'b0);
    applyStimulus(AND, 5'd12, 65'h0_0000_0000_0000_000C, 1'b0, 1'b0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = SHIFTL;
    in_dest   = 5'd15;
    in_result = 65'h0_0000_0000_0000_000F;
    flush     = 1'b1;
    #1;
    checkOutput("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_pending", {61'd0, pending}, 64'd0);
    rf_stall = 1'b0;
    idleCycles(4);
    checkOutput("flush_no_write", write_count, writes_before);
    checkOutput("flush_carry",   {63'd0, carry_flag}, 64'd1);
    checkOutput("flush_pending_after", {61'd0, pending}, 64'd0);

    // Zero flag: XOR producing 0, then a nonzero value from another opcode.
    applyStimulus(XOR, 5'd13, 65'h0_0000_0000_0000_0000, 1'b1, 1'b1);
    idleCycles(2);
`ifdef ALU_WB_ZERO_FLAG_EN
    checkOutput("zero_after_zero", {63'd0, zero_flag}, 64'd1);
`else
    checkOutput("zero_after_zero", {63'd0, zero_flag}, 64'd0);
`endif
    applyStimulus(PASS, 5'd14, 65'h1_0000_0000_0000_0005, 1'b1, 1'b1);
    idleCycles(2);
    checkOutput("zero_after_five", {63'd0, zero_flag}, 64'd0);

    // Asynchronous reset in the middle of a drain.
    rf_stall = 1'b1;
    applyStimulus(SHIFTL, 5'd20, 65'h1_0000_0000_0000_0014, 1'b1, 1'b1);
    applyStimulus(SHIFTL, 5'd21, 65'h1_0000_0000_0000_0015, 1'b0, 1'b0);
    applyStimulus(SHIFTL, 5'd22, 65'h1_0000_0000_0000_0016, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rf_stall = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_rf_we",    {63'd0, rf_we},      64'd0);
    checkOutput("areset_rf_waddr", {59'd0, rf_waddr},   64'd0);
    checkOutput("areset_rf_wdata", rf_wdata,            64'd0);
    checkOutput("areset_carry",    {63'd0, carry_flag}, 64'd0);
    checkOutput("areset_zero",     {63'd0, zero_flag},  64'd0);
    checkOutput("areset_pending",  {61'd0, pending},    64'd0);
    checkOutput("areset_in_ready", {63'd0, in_ready},   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idleCycles(3);
    checkOutput("post_reset_pending", {61'd0, pending}, 64'd0);
    checkOutput("scoreboard_empty", exp_q.size(), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
